// File: rtl/dcache_stage_pkg.sv
// Shared widths, stall encodings, load types and FSM states for the DC stage.
// The DC_ALIGN_CHECK_EN option is consumed by dcache_stage.sv.
package dcache_stage_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int StallBus   = 6;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [2:0] LD_LB  = 3'd0;
    localparam logic [2:0] LD_LBU = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LHU = 3'd3;
    localparam logic [2:0] LD_LW  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } dc_state_e;

    typedef struct packed {
        logic                  we;
        logic [RegAddrBus-1:0] waddr;
        logic [RegBus-1:0]     wdata;
        logic [4:0]            ram_ctrl;
        logic [2:0]            ld_type;
        logic [RegBus-1:0]     addr;
        logic [RegBus-1:0]     st_data;
    } dc_entry_t;

    function automatic logic is_load(input logic [4:0] ram_ctrl);
        return ram_ctrl[4] && (ram_ctrl[3:0] == 4'b0000);
    endfunction

endpackage

// File: rtl/dcache_stage_load_align.sv
// Combinational load-data aligner: picks the byte/half lane from the word
// returned by the data port and sign- or zero-extends it.
module load_align
    import dcache_stage_pkg::*;
(
    input  logic [2:0]        ld_type,
    input  logic [1:0]        addr,
    input  logic [RegBus-1:0] rdata,
    output logic [RegBus-1:0] aligned
);

    logic [RegBus-1:0] shifted;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;

    assign shifted   = rdata >> {addr, 3'b000};
    assign byte_lane = shifted[7:0];
    assign half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        aligned = rdata;
        case (ld_type)
            LD_LB:   aligned = {{24{byte_lane[7]}}, byte_lane};
            LD_LBU:  aligned = {24'h0, byte_lane};
            LD_LH:   aligned = {{16{half_lane[15]}}, half_lane};
            LD_LHU:  aligned = {16'h0, half_lane};
            default: aligned = rdata;
        endcase
    end

endmodule

// File: rtl/dcache_stage.sv
// EX->MEM data-memory access stage: pipeline register, sram-like request FSM,
// load alignment, forwarding view and MEM register. Option: DC_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | no access in flight; issue request for a memory entry
// WAIT  | address accepted, waiting for data_data_ok
// DONE  | response captured, waiting for the stage to advance
// DRAIN | flushed while in flight; swallow the pending response
module dcache_stage
    import dcache_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [StallBus-1:0]   stall,
    input  logic                  ex_we,
    input  logic [RegAddrBus-1:0] ex_waddr,
    input  logic [RegBus-1:0]     ex_wdata,
    input  logic [4:0]            ex_ram_ctrl,
    input  logic [2:0]            ex_ld_type,
    input  logic [RegBus-1:0]     ex_mem_addr,
    input  logic [RegBus-1:0]     ex_st_data,
    output logic                  dcache_we,
    output logic [RegAddrBus-1:0] dcache_waddr,
    output logic [RegBus-1:0]     dcache_wdata,
    output logic [4:0]            dc_ram_ctrl,
    output logic                  mem_we,
    output logic [RegAddrBus-1:0] mem_waddr,
    output logic [RegBus-1:0]     mem_wdata,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [3:0]            data_wstrb,
    output logic [RegBus-1:0]     data_addr,
    output logic [RegBus-1:0]     data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [RegBus-1:0]     data_rdata,
    output logic                  stallreq_for_dcache,
    output logic                  dc_adel,
    output logic                  dc_ades
);

    dc_entry_t         entry;
    dc_entry_t         entry_in;
    dc_state_e         state;
    dc_state_e         state_next;
    logic [RegBus-1:0] ld_buf;
    logic [RegBus-1:0] aligned;
    logic              ld_capture;
    logic              entry_load;
    logic              adel;
    logic              ades;
    logic              fault;
    logic              access;
    logic              unused_stall;

    assign unused_stall = ^{stall[5], stall[2:0]};

    assign entry_in = '{we:       ex_we,
                        waddr:    ex_waddr,
                        wdata:    ex_wdata,
                        ram_ctrl: ex_ram_ctrl,
                        ld_type:  ex_ld_type,
                        addr:     ex_mem_addr,
                        st_data:  ex_st_data};

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            entry <= '0;
        end else if (stall[3] == Stop && stall[4] == NoStop) begin
            entry <= '0;
        end else if (stall[3] == NoStop) begin
            entry <= entry_in;
        end
    end

    assign entry_load = is_load(entry.ram_ctrl);

`ifdef DC_ALIGN_CHECK_EN
    logic entry_store;
    assign entry_store = entry.ram_ctrl[4] && (entry.ram_ctrl[3:0] != 4'b0000);
    assign adel = entry_load &&
                  ((((entry.ld_type == LD_LH) || (entry.ld_type == LD_LHU)) && entry.addr[0]) ||
                   ((entry.ld_type == LD_LW) && (entry.addr[1:0] != 2'b00)));
    assign ades = entry_store &&
                  ((((entry.ram_ctrl[3:0] == 4'b0011) || (entry.ram_ctrl[3:0] == 4'b1100)) && entry.addr[0]) ||
                   ((entry.ram_ctrl[3:0] == 4'b1111) && (entry.addr[1:0] != 2'b00)));
`else
    assign adel = 1'b0;
    assign ades = 1'b0;
`endif

    assign fault  = adel || ades;
    assign access = entry.ram_ctrl[4] && !fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        data_req   = 1'b0;
        ld_capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access && !flush) begin
                    data_req = 1'b1;
                    if (data_addr_ok) state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response arriving with flush is dropped on the floor.
                if (data_data_ok) begin
                    ld_capture = !flush;
                    state_next = flush ? ST_IDLE : ST_DONE;
                end else if (flush) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (stall[4] == NoStop || flush) state_next = ST_IDLE;
            end
            ST_DRAIN: begin
                if (data_data_ok) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    load_align u_load_align (
        .ld_type (entry.ld_type),
        .addr    (entry.addr[1:0]),
        .rdata   (data_rdata),
        .aligned (aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_buf <= '0;
        end else if (ld_capture) begin
            ld_buf <= aligned;
        end
    end

    assign data_wr    = |entry.ram_ctrl[3:0];
    assign data_wstrb = entry.ram_ctrl[3:0];
    assign data_addr  = {entry.addr[31:2], 2'b00};
    assign data_wdata = entry.st_data;

    assign stallreq_for_dcache = (access && state != ST_DONE) || (state == ST_DRAIN);

    assign dcache_we    = entry.we && !fault;
    assign dcache_waddr = entry.waddr;
    assign dcache_wdata = entry_load ? ld_buf : entry.wdata;
    assign dc_ram_ctrl  = entry.ram_ctrl;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            dc_adel   <= 1'b0;
            dc_ades   <= 1'b0;
        end else if (stall[4] == NoStop) begin
            mem_we    <= dcache_we;
            mem_waddr <= dcache_waddr;
            mem_wdata <= dcache_wdata;
            dc_adel   <= adel;
            dc_ades   <= ades;
        end
    end

endmodule

// File: tb/tb_dcache_stage.sv
// Directed self-checking bench for dcache_stage; models the pipeline stall
// controller (DC stall request freezes stages 0..4) and the sram-like bridge.
module tb_dcache_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [5:0]  stall;
    logic        stall_force_en;
    logic [5:0]  stall_force;
    logic        ex_we;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_ram_ctrl;
    logic [2:0]  ex_ld_type;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_st_data;
    logic        dcache_we;
    logic [4:0]  dcache_waddr;
    logic [31:0] dcache_wdata;
    logic [4:0]  dc_ram_ctrl;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        stallreq_for_dcache;
    logic        dc_adel;
    logic        dc_ades;

    int checks = 0;
    int errors = 0;

    assign stall = stall_force_en ? stall_force :
                   (stallreq_for_dcache ? 6'b011111 : 6'b000000);

    dcache_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .stall               (stall),
        .ex_we               (ex_we),
        .ex_waddr            (ex_waddr),
        .ex_wdata            (ex_wdata),
        .ex_ram_ctrl         (ex_ram_ctrl),
        .ex_ld_type          (ex_ld_type),
        .ex_mem_addr         (ex_mem_addr),
        .ex_st_data          (ex_st_data),
        .dcache_we           (dcache_we),
        .dcache_waddr        (dcache_waddr),
        .dcache_wdata        (dcache_wdata),
        .dc_ram_ctrl         (dc_ram_ctrl),
        .mem_we              (mem_we),
        .mem_waddr           (mem_waddr),
        .mem_wdata           (mem_wdata),
        .data_req            (data_req),
        .data_wr             (data_wr),
        .data_wstrb          (data_wstrb),
        .data_addr           (data_addr),
        .data_wdata          (data_wdata),
        .data_addr_ok        (data_addr_ok),
        .data_data_ok        (data_data_ok),
        .data_rdata          (data_rdata),
        .stallreq_for_dcache (stallreq_for_dcache),
        .dc_adel             (dc_adel),
        .dc_ades             (dc_ades)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ex_nop();
        ex_we = 0; ex_waddr = 0; ex_wdata = 0; ex_ram_ctrl = 0;
        ex_ld_type = 0; ex_mem_addr = 0; ex_st_data = 0;
    endtask

    task automatic ex_load(input logic [4:0] wa, input logic [2:0] lt, input logic [31:0] a);
        ex_we = 1; ex_waddr = wa; ex_wdata = 32'hBAD0_BAD0; ex_ram_ctrl = 5'b10000;
        ex_ld_type = lt; ex_mem_addr = a; ex_st_data = 0;
    endtask

    // Load with addr_ok in the request cycle and data_ok the cycle after.
    task automatic do_load(input string tag, input logic [2:0] lt, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] exp);
        ex_load(5'd12, lt, a);
        tick();
        ex_nop();
        chk({tag, "_req"}, {31'b0, data_req}, 32'd1);
        data_addr_ok = 1;
        tick();
        data_addr_ok = 0;
        data_data_ok = 1;
        data_rdata   = rd;
        tick();
        data_data_ok = 0;
        chk({tag, "_stallreq"}, {31'b0, stallreq_for_dcache}, 32'd0);
        chk({tag, "_wdata"}, dcache_wdata, exp);
        tick();
    endtask

    initial begin
        rst = 1; flush = 0; stall_force_en = 0; stall_force = 0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
        ex_nop();
        tick();
        tick();
        chk("rst_dcache_we", {31'b0, dcache_we}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_data_req", {31'b0, data_req}, 32'd0);
        chk("rst_stallreq", {31'b0, stallreq_for_dcache}, 32'd0);
        chk("rst_ram_ctrl", {27'b0, dc_ram_ctrl}, 32'd0);
        rst = 0;

        // ALU op passes straight through
        ex_we = 1; ex_waddr = 5; ex_wdata = 32'h1234;
        tick();
        ex_nop();
        chk("alu_dc_wdata", dcache_wdata, 32'h1234);
        chk("alu_dc_we", {31'b0, dcache_we}, 32'd1);
        chk("alu_stallreq", {31'b0, stallreq_for_dcache}, 32'd0);
        tick();
        chk("alu_mem_wdata", mem_wdata, 32'h1234);
        chk("alu_mem_waddr", {27'b0, mem_waddr}, 32'd5);
        chk("alu_mem_we", {31'b0, mem_we}, 32'd1);

        // LB at 0x103, addr_ok cycle 0, data_ok cycle 2
        ex_load(5'd6, 3'd0, 32'h103);
        tick();
        ex_nop();
        chk("lb_req", {31'b0, data_req}, 32'd1);
        chk("lb_addr", data_addr, 32'h100);
        chk("lb_wr", {31'b0, data_wr}, 32'd0);
        chk("lb_stall0", {31'b0, stallreq_for_dcache}, 32'd1);
        data_addr_ok = 1;
        tick();
        data_addr_ok = 0;
        chk("lb_stall1", {31'b0, stallreq_for_dcache}, 32'd1);
        chk("lb_req_wait", {31'b0, data_req}, 32'd0);
        tick();
        chk("lb_stall2", {31'b0, stallreq_for_dcache}, 32'd1);
        data_data_ok = 1; data_rdata = 32'h80FF_FF7F;
        tick();
        data_data_ok = 0;
        chk("lb_stall3", {31'b0, stallreq_for_dcache}, 32'd0);
        chk("lb_dc_wdata", dcache_wdata, 32'hFFFF_FF80);
        tick();
        chk("lb_mem_wdata", mem_wdata, 32'hFFFF_FF80);
        chk("lb_mem_waddr", {27'b0, mem_waddr}, 32'd6);

        // SW at 0x200
        ex_we = 0; ex_ram_ctrl = 5'b11111; ex_mem_addr = 32'h200; ex_st_data = 32'hDEAD_BEEF;
        tick();
        ex_nop();
        chk("sw_req", {31'b0, data_req}, 32'd1);
        chk("sw_wr", {31'b0, data_wr}, 32'd1);
        chk("sw_wstrb", {28'b0, data_wstrb}, 32'hF);
        chk("sw_wdata", data_wdata, 32'hDEAD_BEEF);
        chk("sw_addr", data_addr, 32'h200);
        chk("sw_ram_ctrl", {27'b0, dc_ram_ctrl}, 32'h1F);
        data_addr_ok = 1;
        tick();
        data_addr_ok = 0;
        data_data_ok = 1;
        chk("sw_stall_wait", {31'b0, stallreq_for_dcache}, 32'd1);
        tick();
        data_data_ok = 0;
        chk("sw_stall_done", {31'b0, stallreq_for_dcache}, 32'd0);
        tick();

        // Flush while waiting for data; response arrives two cycles later
        ex_load(5'd7, 3'd4, 32'h300);
        tick();
        ex_nop();
        data_addr_ok = 1;
        tick();
        data_addr_ok = 0;
        flush = 1;
        tick();
        flush = 0;
        ex_load(5'd8, 3'd4, 32'h400);
        chk("fl_drain_stall", {31'b0, stallreq_for_dcache}, 32'd1);
        chk("fl_drain_req", {31'b0, data_req}, 32'd0);
        chk("fl_dc_we", {31'b0, dcache_we}, 32'd0);
        chk("fl_mem_we", {31'b0, mem_we}, 32'd0);
        tick();
        chk("fl_drain_req2", {31'b0, data_req}, 32'd0);
        data_data_ok = 1; data_rdata = 32'h1111_1111;
        tick();
        data_data_ok = 0;
        chk("fl_idle_req", {31'b0, data_req}, 32'd0);
        chk("fl_idle_stall", {31'b0, stallreq_for_dcache}, 32'd0);
        chk("fl_idle_mem_we", {31'b0, mem_we}, 32'd0);
        tick();
        ex_nop();
        chk("fl_next_req", {31'b0, data_req}, 32'd1);
        chk("fl_next_addr", data_addr, 32'h400);
        data_addr_ok = 1;
        tick();
        data_addr_ok = 0;
        data_data_ok = 1; data_rdata = 32'hCAFE_F00D;
        tick();
        data_data_ok = 0;
        chk("fl_next_wdata", dcache_wdata, 32'hCAFE_F00D);
        tick();
        chk("fl_next_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        chk("fl_next_mem_we", {31'b0, mem_we}, 32'd1);

        // Lane selection and extension
        do_load("lh_hi", 3'd2, 32'h102, 32'h8765_4321, 32'hFFFF_8765);
        do_load("lhu_lo", 3'd3, 32'h100, 32'h8765_C321, 32'h0000_C321);
        do_load("lbu_b1", 3'd1, 32'h101, 32'h0000_9A00, 32'h0000_009A);
        do_load("lb_b0", 3'd0, 32'h100, 32'hFFFF_FF7F, 32'h0000_007F);

        // Misaligned LW
`ifdef DC_ALIGN_CHECK_EN
        ex_load(5'd9, 3'd4, 32'h102);
        tick();
        ex_nop();
        chk("adel_req", {31'b0, data_req}, 32'd0);
        chk("adel_stall", {31'b0, stallreq_for_dcache}, 32'd0);
        chk("adel_dc_we", {31'b0, dcache_we}, 32'd0);
        tick();
        chk("adel_flag", {31'b0, dc_adel}, 32'd1);
        chk("adel_mem_we", {31'b0, mem_we}, 32'd0);
        tick();
`else
        do_load("lw_unaligned", 3'd4, 32'h102, 32'h89AB_CDEF, 32'h89AB_CDEF);
        chk("noadel_flag", {31'b0, dc_adel}, 32'd0);
        chk("noades_flag", {31'b0, dc_ades}, 32'd0);
`endif

        // Hold then bubble
        ex_we = 1; ex_waddr = 10; ex_wdata = 32'h55;
        tick();
        ex_waddr = 11; ex_wdata = 32'h66;
        stall_force_en = 1; stall_force = 6'b011000;
        tick();
        chk("hold_dc_wdata", dcache_wdata, 32'h55);
        stall_force = 6'b001000;
        tick();
        stall_force_en = 0;
        ex_nop();
        chk("bubble_dc_we", {31'b0, dcache_we}, 32'd0);
        chk("bubble_ram_ctrl", {27'b0, dc_ram_ctrl}, 32'd0);
        chk("bubble_mem_wdata", mem_wdata, 32'h55);
        tick();

        // Reset mid-transaction
        ex_load(5'd13, 3'd4, 32'h500);
        tick();
        ex_nop();
        data_addr_ok = 1;
        tick();
        data_addr_ok = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("rst_mid_stall", {31'b0, stallreq_for_dcache}, 32'd0);
        chk("rst_mid_req", {31'b0, data_req}, 32'd0);
        chk("rst_mid_mem_we", {31'b0, mem_we}, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
